// File: rtl/reg_bank_pkg.sv
// Shared definitions for the multi-slot save register bank.
//   bank_mode_t : write mode selected by the modo input
//   MAX_DEPTH   : largest supported number of slots
package reg_bank_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_SEQ  = 1'b1
  } bank_mode_t;

  localparam int MAX_DEPTH = 16;

endpackage

// File: rtl/reg_bank_multi_if.sv
// Switch/button/display bus of the register bank.
//   master : drives activar, guardar, limpiar, modo, wr_sel, rd_sel, entrada
//            and observes salida, valid, ptr, lleno
//   slave  : the register bank itself
interface reg_bank_multi_if #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4
);
  localparam int SELW = $clog2(DEPTH);

  logic             activar;
  logic             guardar;
  logic             limpiar;
  logic             modo;
  logic [SELW-1:0]  wr_sel;
  logic [SELW-1:0]  rd_sel;
  logic [BITS-1:0]  entrada;
  logic [BITS-1:0]  salida;
  logic [DEPTH-1:0] valid;
  logic [SELW-1:0]  ptr;
  logic             lleno;

  modport master (
    output activar, guardar, limpiar, modo, wr_sel, rd_sel, entrada,
    input  salida, valid, ptr, lleno
  );

  modport slave (
    input  activar, guardar, limpiar, modo, wr_sel, rd_sel, entrada,
    output salida, valid, ptr, lleno
  );
endinterface

// File: rtl/reg_bank_multi_edge_rise.sv
// One-cycle rising-edge detector for an already synchronised button level.
//   clk   : system clock
//   rst   : asynchronous, active-low reset
//   in    : button level
//   pulse : high for one cycle after in goes 0->1
// The detector only arms once in has been seen low after reset, so a button
// that is already held when reset releases produces no pulse until it is
// released and pressed again.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic in_q;
  logic armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      in_q  <= in;
      armed <= armed | ~in;
    end
  end

  assign pulse = in & ~in_q & armed;
endmodule

// File: rtl/reg_bank_multi.sv
// Bank of DEPTH registers, BITS wide, loaded from the switch bus on a
// debounced save button, with addressed or circular-log write modes and one
// registered read port.
//   clk : system clock, all state on rising edge
//   rst : asynchronous, active-low reset
//   bus : reg_bank_multi_if slave (activar, guardar, limpiar, modo, wr_sel,
//         rd_sel, entrada in; salida, valid, ptr, lleno out)
module reg_bank_multi
  import reg_bank_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  reg_bank_multi_if.slave  bus
);
  localparam int SELW = $clog2(DEPTH);

  logic             guardar_pulse;
  logic             save;
  logic [BITS-1:0]  slots    [DEPTH];
  logic [BITS-1:0]  slots_nx [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_nx;
  logic [SELW-1:0]  ptr_q, ptr_nx;
  logic             lleno_q, lleno_nx;
  logic [BITS-1:0]  salida_q, salida_nx;
  logic             wr_en;
  logic [SELW-1:0]  wr_idx;

  edge_rise u_save_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (bus.guardar),
    .pulse (guardar_pulse)
  );

  assign save = guardar_pulse & bus.activar;

  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = ptr_q;
    slots_nx  = slots;
    valid_nx  = valid_q;
    ptr_nx    = ptr_q;
    salida_nx = '0;

    if (save && !bus.limpiar) begin
      if (bank_mode_t'(bus.modo) == MODE_SEQ) begin
        wr_en  = 1'b1;
        wr_idx = ptr_q;
        ptr_nx = (ptr_q == SELW'(DEPTH - 1)) ? '0 : ptr_q + SELW'(1);
      end else begin
        // Out-of-range slot numbers (non power-of-two DEPTH) write nothing.
        wr_en  = (32'(bus.wr_sel) < 32'(DEPTH));
        wr_idx = bus.wr_sel;
      end
    end

    // Index by comparison so rd_sel/wr_sel beyond DEPTH never address a slot;
    // an unmatched rd_sel leaves salida_nx at zero.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_en && wr_idx == SELW'(i)) begin
        slots_nx[i] = bus.entrada;
        valid_nx[i] = 1'b1;
      end
      if (bus.rd_sel == SELW'(i)) begin
        salida_nx = (wr_en && wr_idx == bus.rd_sel) ? bus.entrada : slots[i];
      end
    end

    if (bus.limpiar) begin
      slots_nx  = '{default: '0};
      valid_nx  = '0;
      ptr_nx    = '0;
      salida_nx = '0;
    end

    lleno_nx = &valid_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots    <= '{default: '0};
      valid_q  <= '0;
      ptr_q    <= '0;
      lleno_q  <= 1'b0;
      salida_q <= '0;
    end else begin
      slots    <= slots_nx;
      valid_q  <= valid_nx;
      ptr_q    <= ptr_nx;
      lleno_q  <= lleno_nx;
      salida_q <= salida_nx;
    end
  end

  assign bus.salida = salida_q;
  assign bus.valid  = valid_q;
  assign bus.ptr    = ptr_q;
  assign bus.lleno  = lleno_q;
endmodule

// File: tb/tb_reg_bank_multi.sv
module tb_reg_bank_multi;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  reg_bank_multi_if #(.BITS(8), .DEPTH(4)) bus_a ();
  reg_bank_multi_if #(.BITS(8), .DEPTH(3)) bus_b ();

  reg_bank_multi #(.BITS(8), .DEPTH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  reg_bank_multi #(.BITS(8), .DEPTH(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic press_a(input logic [7:0] d);
    bus_a.entrada = d;
    bus_a.guardar = 1'b1;
    @(negedge clk);
    bus_a.guardar = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_b(input logic [7:0] d);
    bus_b.entrada = d;
    bus_b.guardar = 1'b1;
    @(negedge clk);
    bus_b.guardar = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    total_cnt++; if (bus_a.salida !== 8'h00) $display("FAIL rst_salida got %h want 00", bus_a.salida); else pass_cnt++;
    total_cnt++; if (bus_a.valid !== 4'b0000) $display("FAIL rst_valid got %b want 0000", bus_a.valid); else pass_cnt++;
    total_cnt++; if (bus_a.ptr !== 2'd0) $display("FAIL rst_ptr got %0d want 0", bus_a.ptr); else pass_cnt++;
    total_cnt++; if (bus_a.lleno !== 1'b0) $display("FAIL rst_lleno got %b want 0", bus_a.lleno); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addr;
    bus_a.activar = 1'b1;
    bus_a.modo    = 1'b0;
    bus_a.wr_sel  = 2'd2;
    bus_a.rd_sel  = 2'd0;
    bus_a.entrada = 8'hA5;
    bus_a.guardar = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus_a.valid !== 4'b0100) $display("FAIL addr_valid got %b want 0100", bus_a.valid); else pass_cnt++;
    // a second write while held would store 5A instead of A5
    bus_a.entrada = 8'h5A;
    repeat (9) @(negedge clk);
    total_cnt++; if (bus_a.valid !== 4'b0100) $display("FAIL addr_held_valid got %b want 0100", bus_a.valid); else pass_cnt++;
    total_cnt++; if (bus_a.ptr !== 2'd0) $display("FAIL addr_ptr got %0d want 0", bus_a.ptr); else pass_cnt++;
    bus_a.guardar = 1'b0;
    bus_a.rd_sel  = 2'd2;
    total_cnt++; if (bus_a.salida !== 8'h00) $display("FAIL addr_rd_latency got %h want 00", bus_a.salida); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus_a.salida !== 8'hA5) $display("FAIL addr_rd got %h want a5", bus_a.salida); else pass_cnt++;
    total_cnt++; if (bus_a.lleno !== 1'b0) $display("FAIL addr_lleno got %b want 0", bus_a.lleno); else pass_cnt++;
  endtask

  task automatic test_seq_wrap;
    logic [7:0] dv [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [1:0] ep [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] ev [5] = '{4'b0101, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
    logic       el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus_a.modo = 1'b1;
    total_cnt++; if (bus_a.ptr !== 2'd0) $display("FAIL seq_ptr_start got %0d want 0", bus_a.ptr); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      press_a(dv[i]);
      total_cnt++; if (bus_a.ptr !== ep[i]) $display("FAIL seq_ptr[%0d] got %0d want %0d", i, bus_a.ptr, ep[i]); else pass_cnt++;
      total_cnt++; if (bus_a.valid !== ev[i]) $display("FAIL seq_valid[%0d] got %b want %b", i, bus_a.valid, ev[i]); else pass_cnt++;
      total_cnt++; if (bus_a.lleno !== el[i]) $display("FAIL seq_lleno[%0d] got %b want %b", i, bus_a.lleno, el[i]); else pass_cnt++;
    end
    bus_a.rd_sel = 2'd0;
    @(negedge clk);
    total_cnt++; if (bus_a.salida !== 8'h55) $display("FAIL seq_slot0 got %h want 55", bus_a.salida); else pass_cnt++;
    bus_a.rd_sel = 2'd1;
    @(negedge clk);
    total_cnt++; if (bus_a.salida !== 8'h22) $display("FAIL seq_slot1 got %h want 22", bus_a.salida); else pass_cnt++;
    bus_a.rd_sel = 2'd2;
    @(negedge clk);
    total_cnt++; if (bus_a.salida !== 8'h33) $display("FAIL seq_slot2 got %h want 33", bus_a.salida); else pass_cnt++;
  endtask

  task automatic test_gating;
    bus_a.activar = 1'b0;
    press_a(8'h99);
    total_cnt++; if (bus_a.ptr !== 2'd1) $display("FAIL gate_ptr got %0d want 1", bus_a.ptr); else pass_cnt++;
    // activar raised while the button is still held must not revive the press
    bus_a.entrada = 8'h98;
    bus_a.guardar = 1'b1;
    @(negedge clk);
    bus_a.activar = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus_a.ptr !== 2'd1) $display("FAIL gate_held_ptr got %0d want 1", bus_a.ptr); else pass_cnt++;
    bus_a.guardar = 1'b0;
    bus_a.rd_sel  = 2'd1;
    @(negedge clk);
    total_cnt++; if (bus_a.salida !== 8'h22) $display("FAIL gate_slot1 got %h want 22", bus_a.salida); else pass_cnt++;
    bus_a.limpiar = 1'b1;
    bus_a.guardar = 1'b1;
    bus_a.entrada = 8'h77;
    @(negedge clk);
    total_cnt++; if (bus_a.valid !== 4'b0000) $display("FAIL clr_valid got %b want 0000", bus_a.valid); else pass_cnt++;
    total_cnt++; if (bus_a.ptr !== 2'd0) $display("FAIL clr_ptr got %0d want 0", bus_a.ptr); else pass_cnt++;
    total_cnt++; if (bus_a.lleno !== 1'b0) $display("FAIL clr_lleno got %b want 0", bus_a.lleno); else pass_cnt++;
    total_cnt++; if (bus_a.salida !== 8'h00) $display("FAIL clr_salida got %h want 00", bus_a.salida); else pass_cnt++;
    bus_a.limpiar = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus_a.valid !== 4'b0000) $display("FAIL clr_replay_valid got %b want 0000", bus_a.valid); else pass_cnt++;
    total_cnt++; if (bus_a.ptr !== 2'd0) $display("FAIL clr_replay_ptr got %0d want 0", bus_a.ptr); else pass_cnt++;
    bus_a.guardar = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_through;
    bus_a.modo = 1'b1;
    press_a(8'h01);
    bus_a.rd_sel  = 2'd1;
    bus_a.entrada = 8'h3C;
    bus_a.guardar = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus_a.salida !== 8'h3C) $display("FAIL wt_salida got %h want 3c", bus_a.salida); else pass_cnt++;
    total_cnt++; if (bus_a.ptr !== 2'd2) $display("FAIL wt_ptr got %0d want 2", bus_a.ptr); else pass_cnt++;
    bus_a.guardar = 1'b0;
    bus_a.rd_sel  = 2'd0;
    @(negedge clk);
    total_cnt++; if (bus_a.salida !== 8'h01) $display("FAIL wt_slot0 got %h want 01", bus_a.salida); else pass_cnt++;
    // mode switch keeps ptr; the new mode applies from the next save
    bus_a.modo   = 1'b0;
    bus_a.wr_sel = 2'd3;
    press_a(8'hE1);
    total_cnt++; if (bus_a.ptr !== 2'd2) $display("FAIL mode_ptr_kept got %0d want 2", bus_a.ptr); else pass_cnt++;
    total_cnt++; if (bus_a.valid !== 4'b1011) $display("FAIL mode_valid got %b want 1011", bus_a.valid); else pass_cnt++;
    bus_a.modo = 1'b1;
    press_a(8'hF2);
    total_cnt++; if (bus_a.ptr !== 2'd3) $display("FAIL mode_ptr_seq got %0d want 3", bus_a.ptr); else pass_cnt++;
    total_cnt++; if (bus_a.lleno !== 1'b1) $display("FAIL mode_lleno got %b want 1", bus_a.lleno); else pass_cnt++;
    bus_a.rd_sel = 2'd2;
    @(negedge clk);
    total_cnt++; if (bus_a.salida !== 8'hF2) $display("FAIL mode_slot2 got %h want f2", bus_a.salida); else pass_cnt++;
  endtask

  task automatic test_depth3;
    logic [1:0] ep [3] = '{2'd1, 2'd2, 2'd0};
    logic [2:0] ev [3] = '{3'b001, 3'b011, 3'b111};
    bus_b.activar = 1'b1;
    bus_b.modo    = 1'b0;
    bus_b.wr_sel  = 2'd0;
    press_b(8'hC3);
    total_cnt++; if (bus_b.valid !== 3'b001) $display("FAIL d3_valid got %b want 001", bus_b.valid); else pass_cnt++;
    bus_b.rd_sel = 2'd0;
    @(negedge clk);
    total_cnt++; if (bus_b.salida !== 8'hC3) $display("FAIL d3_slot0 got %h want c3", bus_b.salida); else pass_cnt++;
    bus_b.wr_sel = 2'd3;
    press_b(8'hEE);
    total_cnt++; if (bus_b.valid !== 3'b001) $display("FAIL d3_oor_valid got %b want 001", bus_b.valid); else pass_cnt++;
    total_cnt++; if (bus_b.ptr !== 2'd0) $display("FAIL d3_oor_ptr got %0d want 0", bus_b.ptr); else pass_cnt++;
    bus_b.rd_sel = 2'd3;
    @(negedge clk);
    total_cnt++; if (bus_b.salida !== 8'h00) $display("FAIL d3_oor_rd got %h want 00", bus_b.salida); else pass_cnt++;
    bus_b.rd_sel = 2'd0;
    @(negedge clk);
    total_cnt++; if (bus_b.salida !== 8'hC3) $display("FAIL d3_slot0_kept got %h want c3", bus_b.salida); else pass_cnt++;
    bus_b.modo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      press_b(8'(8'h10 * (i + 1)));
      total_cnt++; if (bus_b.ptr !== ep[i]) $display("FAIL d3_ptr[%0d] got %0d want %0d", i, bus_b.ptr, ep[i]); else pass_cnt++;
      total_cnt++; if (bus_b.valid !== ev[i]) $display("FAIL d3_valid[%0d] got %b want %b", i, bus_b.valid, ev[i]); else pass_cnt++;
    end
    total_cnt++; if (bus_b.lleno !== 1'b1) $display("FAIL d3_lleno got %b want 1", bus_b.lleno); else pass_cnt++;
    bus_b.rd_sel = 2'd2;
    @(negedge clk);
    total_cnt++; if (bus_b.salida !== 8'h30) $display("FAIL d3_slot2 got %h want 30", bus_b.salida); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    total_cnt++; if (bus_a.salida !== 8'hF2) $display("FAIL mid_pre_salida got %h want f2", bus_a.salida); else pass_cnt++;
    bus_a.entrada = 8'hAB;
    bus_a.guardar = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (bus_a.salida !== 8'h00) $display("FAIL mid_salida got %h want 00", bus_a.salida); else pass_cnt++;
    total_cnt++; if (bus_a.valid !== 4'b0000) $display("FAIL mid_valid got %b want 0000", bus_a.valid); else pass_cnt++;
    total_cnt++; if (bus_a.ptr !== 2'd0) $display("FAIL mid_ptr got %0d want 0", bus_a.ptr); else pass_cnt++;
    total_cnt++; if (bus_a.lleno !== 1'b0) $display("FAIL mid_lleno got %b want 0", bus_a.lleno); else pass_cnt++;
    total_cnt++; if (bus_b.valid !== 3'b000) $display("FAIL mid_b_valid got %b want 000", bus_b.valid); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus_a.valid !== 4'b0000) $display("FAIL mid_held_valid got %b want 0000", bus_a.valid); else pass_cnt++;
    bus_a.guardar = 1'b0;
    @(negedge clk);
    bus_a.entrada = 8'hCD;
    bus_a.guardar = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus_a.valid !== 4'b0001) $display("FAIL mid_first_valid got %b want 0001", bus_a.valid); else pass_cnt++;
    total_cnt++; if (bus_a.ptr !== 2'd1) $display("FAIL mid_first_ptr got %0d want 1", bus_a.ptr); else pass_cnt++;
    bus_a.guardar = 1'b0;
    bus_a.rd_sel  = 2'd0;
    @(negedge clk);
    total_cnt++; if (bus_a.salida !== 8'hCD) $display("FAIL mid_first_rd got %h want cd", bus_a.salida); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b0;
    bus_a.activar = 1'b0; bus_a.guardar = 1'b0; bus_a.limpiar = 1'b0; bus_a.modo = 1'b0;
    bus_a.wr_sel  = '0;   bus_a.rd_sel  = '0;   bus_a.entrada = '0;
    bus_b.activar = 1'b0; bus_b.guardar = 1'b0; bus_b.limpiar = 1'b0; bus_b.modo = 1'b0;
    bus_b.wr_sel  = '0;   bus_b.rd_sel  = '0;   bus_b.entrada = '0;

    test_reset();
    test_addr();
    test_seq_wrap();
    test_gating();
    test_write_through();
    test_depth3();
    test_reset_mid();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
